real_norm_round: RTL
====================

REAL_NORM_ROUND -- requirements
Module: real_norm_round

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MANT_RAW_W, default 24, significand width including hidden bit (M below).
REQ-003 SHALL have parameter WIDTH, default 32, packed IEEE754 word width; BIAS = 2^(EXP_W-1)-1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream multiplier result valid.
REQ-007 SHALL have port in_ready  output  1  block accepts the input this cycle.
REQ-008 SHALL have port in_sign  input  1  result sign.
REQ-009 SHALL have port in_exp  input  EXP_W+2  signed two's-complement value e_a+e_b-BIAS.
REQ-010 SHALL have port in_mant  input  2*M  raw significand product; binary point between bits 2M-2 and 2M-3.
REQ-011 SHALL have port in_nan  input  1  upstream special case: NaN result.
REQ-012 SHALL have port in_inf  input  1  upstream special case: infinite result.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-015 SHALL have port out_res  output  WIDTH  packed IEEE754 result.
REQ-016 SHALL have port out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-017 SHALL transfer on in_valid&in_ready at input and on out_valid&out_ready at output.
REQ-018 SHALL be a 2-stage pipeline: S1 = leading-zero count, shift, exponent adjust; S2 = round, exception handling, pack.
REQ-019 SHALL have latency 2 cycles from input transfer to out_valid when out_ready is held 1; throughput 1 per cycle.
REQ-020 SHALL advance a stage only when the next stage is empty or is transferring out the same cycle; in_ready = !s1_valid | !s2_valid | out_ready.
REQ-021 SHALL hold out_res and out_flags stable while out_valid&!out_ready; results emerge in order, none lost or duplicated.
REQ-022 S1 SHALL compute lz = leading zeros of in_mant, P = in_mant<<lz, e = in_exp+1-lz, at EXP_W+2 signed width.
REQ-023 S2 SHALL take mantissa = P[2M-2:M], guard G = P[M-1], sticky S = OR(P[M-2:0]).
REQ-024 S2 SHALL round to nearest even: increment the mantissa when G&(S|mantissa LSB); on carry-out, mantissa becomes 0 and e increments by 1.
REQ-025 S2 SHALL set inexact = G|S on the normal path.
REQ-026 SHALL apply this result priority: in_nan -> 0x7FC00000 (canonical quiet NaN, flags 0); else in_inf -> {in_sign, all-ones exp, 0}, flags 0; else in_mant==0 -> signed zero, flags 0.
REQ-027 After rounding, e >= 2^EXP_W-1 SHALL give signed infinity with overflow=1 and inexact=1.
REQ-028 After rounding, e <= 0 SHALL flush the result to signed zero with underflow=1 and inexact=1; no subnormal output is produced.

Reset
REQ-029 While reset is high, all valid bits SHALL clear asynchronously; out_valid=0, out_res=0, out_flags=0; in_ready=1 after reset releases.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight items; no partial result reaches the output.
REQ-031 Datapath registers other than the outputs need not be reset.

Structure
REQ-032 BIAS, the canonical NaN constant and the flag bit indices SHALL live in the shared FP package used by the real_* blocks.
REQ-033 The leading-zero count SHALL reuse the existing zero_counter sub-module (IN_W=2*M, REVERSE=0); no other sub-modules.

Verification
REQ-034 in_exp=128, in_mant=0x600000000000, sign 0 (1.5*2.0) -> out_res=0x40400000, flags 000, 2 cycles later.
REQ-035 in_exp=127, in_mant=0x800001800000 (tie, LSB 1) -> out_res=0x40000002, inexact=1; with in_mant=0x800000800000 (tie, LSB 0) -> out_res=0x40000000, inexact=1.
REQ-036 in_exp=255, in_mant=0x400000000000, sign 1 -> out_res=0xFF800000, flags 101; in_exp=0 with the same mant, sign 0 -> out_res=0x00000000, flags 011.
REQ-037 in_nan=1 together with in_inf=1 -> out_res=0x7FC00000; in_inf=1 alone, sign 1 -> 0xFF800000; in_mant=0 -> signed zero, flags 000.
REQ-038 3 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready drops after 2 are accepted, outputs are held stable, then 3 in-order results once out_ready=1.
REQ-039 reset pulsed while 2 items are in flight -> out_valid=0 immediately, and neither item ever appears at the output.

Source files
------------

// File: rtl/real_norm_round_pkg.sv
// Shared floating-point constants for the real_* arithmetic blocks.
// Holds the exponent bias, canonical quiet NaN and the result flag bit positions.
package real_norm_round_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX  = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/zero_counter.sv
// Zero run-length counter: leading zeros (REVERSE=0) or trailing zeros (REVERSE=1).
// An all-zero input returns IN_W.
module zero_counter #(
  parameter int IN_W    = 48,
  parameter int REVERSE = 0,
  localparam int CNT_W  = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]  data_i,
  output logic [CNT_W-1:0] cnt_o
);

  generate
    if (REVERSE == 0) begin : g_lead
      // Ascending scan: the highest set bit is written last.
      always_comb begin
        cnt_o = CNT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
          if (data_i[i]) cnt_o = CNT_W'(IN_W - 1 - i);
        end
      end
    end else begin : g_trail
      always_comb begin
        cnt_o = CNT_W'(IN_W);
        for (int i = IN_W - 1; i >= 0; i--) begin
          if (data_i[i]) cnt_o = CNT_W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/real_norm_round.sv
// Two-stage normalise/round/pack back end for the floating-point multiplier.
// S1 normalises the raw product, S2 rounds to nearest even and packs IEEE754.
module real_norm_round
  import real_norm_round_pkg::*;
#(
  parameter int EXP_W      = 8,
  parameter int MANT_RAW_W = 24,
  parameter int WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W+1:0]        in_exp,
  input  logic [2*MANT_RAW_W-1:0] in_mant,
  input  logic                    in_nan,
  input  logic                    in_inf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_res,
  output logic [2:0]              out_flags
);

  localparam int M   = MANT_RAW_W;
  localparam int PW  = 2 * M;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(PW + 1);

  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);

  logic [LZW-1:0] lz;

  zero_counter #(
    .IN_W    (PW),
    .REVERSE (0)
  ) u_lzc (
    .data_i (in_mant),
    .cnt_o  (lz)
  );

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic                 s1_nan_q;
  logic                 s1_inf_q;
  logic signed [EW-1:0] s1_e_q;
  logic [PW-1:0]        s1_p_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_res_q;
  logic [2:0]       out_flags_q;
  logic [WIDTH-1:0] out_res_d;
  logic [2:0]       out_flags_d;

  logic s2_free;
  logic s1_adv;
  logic in_fire;

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_flags = out_flags_q;

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_q <= in_sign;
      s1_nan_q  <= in_nan;
      s1_inf_q  <= in_inf;
      s1_e_q    <= in_exp + EW'(1) - EW'(lz);
      s1_p_q    <= in_mant << lz;
    end
  end

  logic [M-2:0]         mant;
  logic [M-2:0]         mant_r;
  logic                 g_bit;
  logic                 s_bit;
  logic                 rnd;
  logic                 cy;
  logic signed [EW-1:0] e_r;

  always_comb begin
    mant        = s1_p_q[PW-2:M];
    g_bit       = s1_p_q[M-1];
    s_bit       = |s1_p_q[M-2:0];
    rnd         = g_bit & (s_bit | mant[0]);
    {cy, mant_r} = {1'b0, mant} + M'(rnd);
    e_r         = s1_e_q + EW'(cy);
    out_res_d   = '0;
    out_flags_d = '0;
    // A normalised product always has its top bit set unless it was zero.
    if (s1_nan_q) begin
      out_res_d = WIDTH'(FP_QNAN);
    end else if (s1_inf_q) begin
      out_res_d = {s1_sign_q, {EXP_W{1'b1}}, {(M-1){1'b0}}};
    end else if (!s1_p_q[PW-1]) begin
      out_res_d = {s1_sign_q, {(WIDTH-1){1'b0}}};
    end else if (e_r >= E_MAX) begin
      out_res_d = {s1_sign_q, {EXP_W{1'b1}}, {(M-1){1'b0}}};
      out_flags_d[FLG_OVF] = 1'b1;
      out_flags_d[FLG_NX]  = 1'b1;
    end else if (e_r < E_ONE) begin
      out_res_d = {s1_sign_q, {(WIDTH-1){1'b0}}};
      out_flags_d[FLG_UNF] = 1'b1;
      out_flags_d[FLG_NX]  = 1'b1;
    end else begin
      out_res_d = {s1_sign_q, e_r[EXP_W-1:0], mant_r};
      out_flags_d[FLG_NX] = g_bit | s_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
    end else begin
      // When in_ready is high S1 is either empty or handing off this cycle.
      if (in_ready) s1_valid_q <= in_valid;
      if (s2_free) out_valid_q <= s1_valid_q;
      if (s1_adv) begin
        out_res_q   <= out_res_d;
        out_flags_q <= out_flags_d;
      end
    end
  end

endmodule
